// File: rtl/scan_chain_mc.sv
// Multi-chain scan controller: per-chain shift registers with capture, serial shift
// and shadow-register update, driven by a single-command valid/ready interface.
module scan_chain_mc #(
  parameter int NUM_SCAN_BITS = 36,
  parameter int NUM_CHAINS    = 4,
  localparam int CH_W  = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1,
  localparam int CNT_W = $clog2(NUM_SCAN_BITS + 1) + 1
) (
  input  logic                                clk1,
  input  logic                                rst_n,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [1:0]                          cmd_op,
  input  logic [CH_W-1:0]                     cmd_chain,
  input  logic [CNT_W-1:0]                    cmd_len,
  input  logic                                scan_in,
  output logic                                scan_out,
  input  logic [NUM_CHAINS*NUM_SCAN_BITS-1:0] par_in,
  output logic [NUM_CHAINS*NUM_SCAN_BITS-1:0] scan_reg,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  // state    | meaning
  // ST_IDLE  | waiting for a command, cmd_ready high
  // ST_CAPT  | one cycle, selected shift register loads par_in slice
  // ST_SHIFT | len cycles, serial shift through the selected chain
  // ST_UPDT  | one cycle, selected scan_reg slice loads the shift register
  // ST_DONE  | one cycle completion pulse, err flags an illegal chain
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAPT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_UPDT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_SHIFT   = 2'b00;
  localparam logic [1:0] OP_CAPTURE = 2'b01;
  localparam logic [1:0] OP_UPDATE  = 2'b10;
  localparam logic [1:0] OP_FULL    = 2'b11;

  localparam int N = NUM_SCAN_BITS;
  localparam int W = NUM_CHAINS * NUM_SCAN_BITS;
  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(NUM_CHAINS);

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [CH_W-1:0]  sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [W-1:0]     sr_q;
  logic [W-1:0]     scan_reg_q;
  logic             accept;
  logic             legal_chain;
  logic [CH_W-1:0]  sel_cur;
  logic             scan_out_c;

  assign legal_chain = ({1'b0, cmd_chain} < CH_LIMIT);
  assign accept      = cmd_valid && (state_q == ST_IDLE);
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = ~cmd_ready;
  assign done        = (state_q == ST_DONE);
  assign err         = done & err_q;
  assign scan_reg    = scan_reg_q;
  assign sel_cur     = (state_q == ST_IDLE) ? cmd_chain : sel_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!legal_chain) begin
            state_d = ST_DONE;
          end else begin
            case (cmd_op)
              OP_SHIFT:   state_d = (cmd_len == '0) ? ST_DONE : ST_SHIFT;
              OP_UPDATE:  state_d = ST_UPDT;
              OP_CAPTURE: state_d = ST_CAPT;
              default:    state_d = ST_CAPT;
            endcase
          end
        end
      end
      ST_CAPT: begin
        if (op_q == OP_FULL) state_d = (cnt_q == '0) ? ST_UPDT : ST_SHIFT;
        else                 state_d = ST_DONE;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(1)) state_d = (op_q == OP_FULL) ? ST_UPDT : ST_DONE;
      end
      ST_UPDT: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // cnt_q holds the latched length until SHIFT, then counts it down
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= cmd_op;
      sel_q <= cmd_chain;
      cnt_q <= cmd_len;
      err_q <= ~legal_chain;
    end else if (state_q == ST_SHIFT) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // illegal chains never reach CAPT/SHIFT/UPDT, so they cannot touch any chain
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      scan_reg_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHAINS; c++) begin
        if (sel_q == CH_W'(c)) begin
          if (state_q == ST_CAPT)
            sr_q[c*N +: N] <= par_in[c*N +: N];
          else if (state_q == ST_SHIFT)
            sr_q[c*N +: N] <= {sr_q[c*N +: N-1], scan_in};
          else if (state_q == ST_UPDT)
            scan_reg_q[c*N +: N] <= sr_q[c*N +: N];
        end
      end
    end
  end

  always_comb begin
    scan_out_c = 1'b0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      if (sel_cur == CH_W'(c)) scan_out_c = sr_q[c*N + N - 1];
    end
  end

  assign scan_out = scan_out_c;

endmodule

// File: tb/tb_scan_chain_mc.sv
// Bench for scan_chain_mc: a 2-chain and a 3-chain instance (8 cells each) checked
// against a transaction-level model of the shift and shadow registers.
module tb_scan_chain_mc;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        cmd_valid_a, cmd_valid_b;
  logic        cmd_ready_a, cmd_ready_b;
  logic [1:0]  cmd_op;
  logic [0:0]  cmd_chain_a;
  logic [1:0]  cmd_chain_b;
  logic [4:0]  cmd_len;
  logic        scan_in;
  logic        scan_out_a, scan_out_b;
  logic [15:0] par_in_a, scan_reg_a;
  logic [23:0] par_in_b, scan_reg_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_sr [2][3];
  logic [7:0] m_sh [2][3];

  always #5 clk1 = ~clk1;

  scan_chain_mc #(.NUM_SCAN_BITS(8), .NUM_CHAINS(2)) dut_a (
    .clk1(clk1), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_op(cmd_op), .cmd_chain(cmd_chain_a), .cmd_len(cmd_len), .scan_in(scan_in),
    .scan_out(scan_out_a), .par_in(par_in_a), .scan_reg(scan_reg_a),
    .busy(busy_a), .done(done_a), .err(err_a));

  scan_chain_mc #(.NUM_SCAN_BITS(8), .NUM_CHAINS(3)) dut_b (
    .clk1(clk1), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_chain(cmd_chain_b), .cmd_len(cmd_len), .scan_in(scan_in),
    .scan_out(scan_out_b), .par_in(par_in_b), .scan_reg(scan_reg_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  function automatic logic obs_ready(int d);  return d ? cmd_ready_b : cmd_ready_a; endfunction
  function automatic logic obs_busy(int d);   return d ? busy_b : busy_a;           endfunction
  function automatic logic obs_done(int d);   return d ? done_b : done_a;           endfunction
  function automatic logic obs_err(int d);    return d ? err_b : err_a;             endfunction
  function automatic logic obs_out(int d);    return d ? scan_out_b : scan_out_a;   endfunction
  function automatic logic [23:0] obs_reg(int d);
    return d ? scan_reg_b : {8'h00, scan_reg_a};
  endfunction
  function automatic logic [23:0] exp_reg(int d);
    return d ? {m_sh[1][2], m_sh[1][1], m_sh[1][0]} : {8'h00, m_sh[0][1], m_sh[0][0]};
  endfunction

  task automatic model_reset;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++) begin
        m_sr[d][c] = 8'h00;
        m_sh[d][c] = 8'h00;
      end
  endtask

  // One command on instance d; the model applies capture/shift/update in the
  // cycle slots implied by the operation's documented latency.
  task automatic run_cmd(input int d, input logic [1:0] op, input int ch, input int len,
                         input logic [23:0] par, input logic [31:0] fixed_bits,
                         input bit use_fixed, input string tag);
    int  nch, lat, guard, sh_idx;
    bit  illegal, is_capt, is_shift, is_updt;
    nch     = d ? 3 : 2;
    illegal = (ch >= nch);
    lat     = illegal ? 1 : (op == 2'b00) ? len + 1 : (op == 2'b11) ? len + 3 : 2;
    guard   = 0;
    @(negedge clk1);
    while (!obs_ready(d) && guard < 100) begin
      @(negedge clk1);
      guard++;
    end
    total++;
    if (guard >= 100) begin
      bad++;
      $display("FAIL %s ready_wait: cmd_ready=0 required=1", tag);
    end
    par_in_a    = par[15:0];
    par_in_b    = par;
    cmd_op      = op;
    cmd_chain_a = ch[0:0];
    cmd_chain_b = ch[1:0];
    cmd_len     = len[4:0];
    scan_in     = 1'($urandom);
    if (d != 0) cmd_valid_b = 1'b1;
    else        cmd_valid_a = 1'b1;
    @(posedge clk1);
    sh_idx = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk1);
      cmd_valid_a = 1'b0;
      cmd_valid_b = 1'b0;
      total++;
      if (obs_done(d) !== (k == lat)) begin
        bad++;
        $display("FAIL %s done k=%0d: got=%0b required=%0b", tag, k, obs_done(d), (k == lat));
      end
      total++;
      if (obs_err(d) !== (k == lat && illegal)) begin
        bad++;
        $display("FAIL %s err k=%0d: got=%0b required=%0b", tag, k, obs_err(d), (k == lat && illegal));
      end
      total++;
      if (obs_ready(d) !== 1'b0 || obs_busy(d) !== 1'b1) begin
        bad++;
        $display("FAIL %s ready/busy k=%0d: got=%0b/%0b required=0/1", tag, k, obs_ready(d), obs_busy(d));
      end
      is_capt  = !illegal && (op == 2'b01 || op == 2'b11) && k == 1;
      is_shift = !illegal && ((op == 2'b00 && k <= len) || (op == 2'b11 && k >= 2 && k <= len + 1));
      is_updt  = !illegal && ((op == 2'b10 && k == 1) || (op == 2'b11 && k == len + 2));
      if (!illegal) begin
        total++;
        if (obs_out(d) !== m_sr[d][ch][7]) begin
          bad++;
          $display("FAIL %s scan_out k=%0d: got=%0b required=%0b", tag, k, obs_out(d), m_sr[d][ch][7]);
        end
      end
      scan_in = use_fixed ? fixed_bits[sh_idx] : 1'($urandom);
      if (is_capt) m_sr[d][ch] = par[ch*8 +: 8];
      if (is_shift) begin
        m_sr[d][ch] = {m_sr[d][ch][6:0], scan_in};
        sh_idx++;
      end
      if (is_updt) m_sh[d][ch] = m_sr[d][ch];
    end
    @(negedge clk1);
    total++;
    if (obs_ready(d) !== 1'b1 || obs_done(d) !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: ready=%0b done=%0b required=1/0", tag, obs_ready(d), obs_done(d));
    end
    total++;
    if (obs_reg(d) !== exp_reg(d)) begin
      bad++;
      $display("FAIL %s scan_reg: got=%h required=%h", tag, obs_reg(d), exp_reg(d));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (scan_reg_a !== 16'h0000 || scan_reg_b !== 24'h000000) begin
      bad++;
      $display("FAIL %s scan_reg: got=%h/%h required=0/0", tag, scan_reg_a, scan_reg_b);
    end
    total++;
    if (scan_out_a !== 1'b0 || cmd_ready_a !== 1'b1 || busy_a !== 1'b0 ||
        done_a !== 1'b0 || err_a !== 1'b0) begin
      bad++;
      $display("FAIL %s outputs: out=%0b ready=%0b busy=%0b done=%0b err=%0b required=0 1 0 0 0",
               tag, scan_out_a, cmd_ready_a, busy_a, done_a, err_a);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_op = 2'b00; cmd_chain_a = '0; cmd_chain_b = '0; cmd_len = '0;
    scan_in = 1'b0; par_in_a = '0; par_in_b = '0;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic test_full_directed;
    run_cmd(0, 2'b11, 1, 8, 24'h00A55A, 32'h0000_004D, 1'b1, "full_directed");
    run_cmd(0, 2'b11, 0, 0, 24'h00003C, 32'h0, 1'b0, "full_len0");
  endtask

  task automatic test_len_zero;
    run_cmd(0, 2'b00, 1, 0, 24'h0, 32'h0, 1'b0, "shift_len0");
  endtask

  task automatic test_long_shift;
    run_cmd(0, 2'b00, 0, 11, 24'h0, 32'h0, 1'b0, "shift_len11");
    run_cmd(0, 2'b10, 0, 0, 24'h0, 32'h0, 1'b0, "update_after_long");
  endtask

  task automatic test_bad_chain;
    run_cmd(1, 2'b11, 2, 5, 24'h5A3C99, 32'h0, 1'b0, "prep_b");
    run_cmd(1, 2'b11, 3, 5, 24'hFFFFFF, 32'h0, 1'b0, "bad_chain_full");
    run_cmd(1, 2'b10, 3, 0, 24'h0, 32'h0, 1'b0, "bad_chain_update");
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      int d, ch, len;
      d   = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ch  = d ? $urandom_range(0, 3) : $urandom_range(0, 1);
      len = $urandom_range(0, 13);
      run_cmd(d, 2'($urandom), ch, len, 24'($urandom), 32'h0, 1'b0, "random");
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk1);
    cmd_op = 2'b00; cmd_chain_a = 1'b1; cmd_len = 5'd20; cmd_valid_a = 1'b1;
    @(posedge clk1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk1);
      cmd_valid_a = 1'b0;
      scan_in = 1'b1;
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("abort_async");
    @(negedge clk1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk1);
      total++;
      if (done_a !== 1'b0 || cmd_ready_a !== 1'b1) begin
        bad++;
        $display("FAIL abort_no_done: done=%0b ready=%0b required=0/1", done_a, cmd_ready_a);
      end
    end
    run_cmd(0, 2'b11, 1, 3, 24'h00C300, 32'h0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back;
    int n_acc, first_acc, second_acc, low_cnt;
    bit exp_rdy, exp_dn;
    n_acc = 0; first_acc = -1; second_acc = -1; low_cnt = 0;
    @(negedge clk1);
    cmd_op = 2'b10; cmd_chain_a = 1'b0; cmd_valid_a = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) @(negedge clk1);
      if (i == 1) cmd_chain_a = 1'b1;
      if (i == 4) cmd_valid_a = 1'b0;
      exp_rdy = (i == 0 || i == 3 || i == 6);
      exp_dn  = (i == 2 || i == 5);
      total++;
      if (cmd_ready_a !== exp_rdy || done_a !== exp_dn) begin
        bad++;
        $display("FAIL b2b cycle %0d: ready=%0b done=%0b required=%0b/%0b",
                 i, cmd_ready_a, done_a, exp_rdy, exp_dn);
      end
      if (cmd_ready_a === 1'b1 && cmd_valid_a) begin
        if (n_acc == 0) first_acc = i;
        else            second_acc = i;
        n_acc++;
      end else if (n_acc == 1 && cmd_ready_a === 1'b0) begin
        low_cnt++;
      end
      if (i == 1) m_sh[0][0] = m_sr[0][0];
      if (i == 4) m_sh[0][1] = m_sr[0][1];
    end
    total++;
    if (second_acc - first_acc != 3 || low_cnt != 2) begin
      bad++;
      $display("FAIL b2b spacing: gap=%0d low=%0d required=3/2", second_acc - first_acc, low_cnt);
    end
    total++;
    if (scan_reg_a !== exp_reg(0)[15:0]) begin
      bad++;
      $display("FAIL b2b scan_reg: got=%h required=%h", scan_reg_a, exp_reg(0)[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_directed();
    test_len_zero();
    test_long_shift();
    test_bad_chain();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
